// File: rtl/input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : input_buffer
// Purpose  : Per-port NOC router input FIFO with FWFT head flit, packet header
//            tracking, credit return and sticky overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
module input_buffer #(
    parameter int DEPTH   = 4,
    parameter int FLIT_W  = 32,
    parameter int PKT_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ib_write_i,
    input  logic [FLIT_W-1:0]          ib_flit_i,
    input  logic                       ib_read_i,
    output logic [FLIT_W-1:0]          ib_flit_o,
    output logic                       ib_empty_o,
    output logic                       ib_full_o,
    output logic [$clog2(DEPTH+1)-1:0] ib_count_o,
    output logic [7:0]                 ib_addr_header_o,
    output logic                       ib_credit_o,
    output logic                       ib_overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PKT_W = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PKT_W-1:0] LAST_FLIT = PKT_W'(PKT_LEN - 1);

    logic [FLIT_W-1:0] mem_q [0:DEPTH-1];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PKT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]       hdr_q, hdr_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic [FLIT_W-1:0] head_flit;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign pop       = ib_read_i & ~empty;
    // A pop in the same cycle frees the slot the incoming flit will occupy.
    assign push      = ib_write_i & (~full | pop);
    assign head_flit = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_cnt_d   = rd_cnt_q;
        hdr_d      = hdr_q;
        credit_d   = pop;
        overflow_d = overflow_q | (ib_write_i & ~push);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (rd_cnt_q == '0) begin
                hdr_d = head_flit[7:0];
            end
            if (rd_cnt_q == LAST_FLIT) begin
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + PKT_W'(1);
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_cnt_q   <= '0;
            hdr_q      <= 8'h00;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_cnt_q   <= rd_cnt_d;
            hdr_q      <= hdr_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; occupancy tracking alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ib_flit_i;
        end
    end

    assign ib_flit_o        = head_flit;
    assign ib_empty_o       = empty;
    assign ib_full_o        = full;
    assign ib_count_o       = count_q;
    assign ib_credit_o      = credit_q;
    assign ib_overflow_o    = overflow_q;
    assign ib_addr_header_o = ((rd_cnt_q == '0) && !empty) ? head_flit[7:0] : hdr_q;

endmodule
`default_nettype wire

// File: doc/input_buffer.md
# input_buffer

Per-port input FIFO for the NOC router; one instance per direction (n, s, w, e, l). It stores incoming flits and presents the head flit to the crossbar. It drives the arbiter's `ib_empty_*` and `yx_*_addr_header_*` inputs and pops on the arbiter's `rrp_*_priority_read_o`. Each pop returns one credit upstream.

## Interface
- `DEPTH`, 4: flit slots; power of two, at least 2.
- `FLIT_W`, 32: flit width in bits; at least 8.
- `PKT_LEN`, 4: flits per packet, header included; at least 2. Flit 0 of each packet is the header, and its bits [7:0] carry the yx destination address.

All ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ib_write_i` in 1: upstream flit valid. Upstream honours credits; a write to a full buffer is an error.
- `ib_flit_i` in FLIT_W: incoming flit.
- `ib_read_i` in 1: pop request from the arbiter.
- `ib_flit_o` out FLIT_W: head flit, first-word-fall-through.
- `ib_empty_o` out 1: buffer holds no flits.
- `ib_full_o` out 1: buffer holds DEPTH flits.
- `ib_count_o` out $clog2(DEPTH+1): occupancy.
- `ib_addr_header_o` out 8: yx address of the packet at the head.
- `ib_credit_o` out 1: one-cycle pulse per accepted pop.
- `ib_overflow_o` out 1: sticky error flag.

## Operation
- Storage is a DEPTH x FLIT_W register array with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy is held in the `count` register, with range 0..DEPTH.
  - `ib_empty_o` = (count == 0).
  - `ib_full_o` = (count == DEPTH).
- Pop:
  - `pop` = `ib_read_i` & !`ib_empty_o`.
  - A read while empty is ignored: no pointer move, no credit.
- Push:
  - `push` = `ib_write_i` & (!`ib_full_o` | `pop`).
  - A write while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the flit is dropped and `ib_overflow_o` sets. The flag clears only on reset.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous push and pop while empty: the pop is not valid (empty), so only the push takes effect.
- Flit tracker (`rd_cnt`, range 0..PKT_LEN-1):
  - Increments on each pop and wraps to 0 after flit PKT_LEN-1.
  - `rd_cnt` == 0 means the head flit is a header.
- Header register `hdr_q` (8 bits) loads `mem[rd_ptr][7:0]` on a pop with `rd_cnt` == 0.
- `ib_addr_header_o`:
  - Equals `mem[rd_ptr][7:0]` when `rd_cnt` == 0 and the buffer is non-empty.
  - Otherwise equals `hdr_q`.
  - The address stays stable for the whole packet, including while the body drains or the buffer is empty mid-packet.
- `ib_flit_o` = `mem[rd_ptr]` at all times. Its contents are don't-care when empty.
- `ib_credit_o` is registered: it is high in the cycle after each pop.

## Timing
- Reset values while `reset` = 0, applied asynchronously:
  - pointers 0, count 0, `rd_cnt` 0, `hdr_q` 8'h00
  - `ib_empty_o` 1, `ib_full_o` 0, `ib_count_o` 0
  - `ib_credit_o` 0, `ib_overflow_o` 0, `ib_addr_header_o` 8'h00
  - Array contents are not reset.
- Reset released mid-packet: all tracking restarts, so the next written flit is treated as a header.
- Write latency:
  - A flit written at edge k is visible on `ib_flit_o` in the cycle after edge k.
  - `ib_empty_o` falls and count updates in the same cycle.
- Read latency:
  - `ib_read_i` is sampled at edge k. The next flit is presented, and `ib_credit_o` is high, in the cycle after edge k.
  - Sustained throughput is one pop per cycle.
- Full-throughput streaming: push and pop every cycle keeps count constant. Credits pulse every cycle.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Ordering is preserved across wrap.

## Test plan
- Reset:
  - Assert `reset`=0 mid-cycle.
  - Required: all outputs immediately at their reset values (`ib_empty_o`=1, `ib_count_o`=0, `ib_addr_header_o`=8'h00).
- Single packet (DEPTH=4, PKT_LEN=4):
  - Write header 32'h0000_0023, then bodies 32'hB1, 32'hB2, 32'hB3, then pop 4 times.
  - Required: `ib_addr_header_o`=8'h23 through all four pops; flits out in order; 4 credit pulses; `ib_empty_o`=1 at the end; `ib_addr_header_o` remains 8'h23.
- Full and overflow:
  - Write 5 flits with no reads.
  - Required: `ib_full_o`=1 after the 4th write; the 5th is dropped; `ib_overflow_o`=1 and sticky; `ib_count_o`=4.
- Simultaneous push and pop at full:
  - Hold `ib_write_i`=`ib_read_i`=1 for 8 cycles.
  - Required: count stays 4; no overflow; 8 credit pulses; FIFO order preserved across pointer wrap.
- Read when empty:
  - Assert `ib_read_i` for 3 cycles with the buffer empty.
  - Required: no credit pulses; count stays 0; `rd_cnt` unchanged, so the next written flit is reported as the header.
- Back-to-back packets:
  - Write header 8'h12 plus 3 bodies, then header 8'h34 plus 3 bodies, popping continuously.
  - Required: `ib_addr_header_o` switches from 8'h12 to 8'h34 exactly when the second header reaches the head.
